// File: rtl/blc_offset_est_pkg.sv
// Shared ISP package for the black-level offset estimator.
// Holds the handshake event encodings, the default channel width, the aux
// sideband bit positions that every stage in the pipe agrees on, and the
// estimator state codes.
package blc_offset_est_pkg;

    // Default bits per colour channel.
    localparam int DEFAULT_DATA_WIDTH = 12;

    // Aux sideband bit positions.
    localparam int AUX_OB_BIT  = 0;
    localparam int AUX_SOF_BIT = 1;

    // Handshake events, encoded as {insert, remove}.
    localparam logic [1:0] HS_NONE   = 2'b00;
    localparam logic [1:0] HS_REMOVE = 2'b01;
    localparam logic [1:0] HS_INSERT = 2'b10;

    // Estimator FSM state codes.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/blc_ob_accum.sv
// Per-channel optical-black accumulator with shift-average.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear        : discard the running sum (start of frame)
//   add          : add sample into the (possibly just cleared) sum
//   sample       : channel value of the current beat
//   average      : (sum including this beat's sample) >> LOG2_SAMPLES,
//                  meaningful on the beat that completes the sample set
module blc_ob_accum
    import blc_offset_est_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int LOG2_SAMPLES = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  add,
    input  logic [DATA_WIDTH-1:0] sample,
    output logic [DATA_WIDTH-1:0] average
);

    // Wide enough for 2^LOG2_SAMPLES full-scale samples, so no overflow.
    localparam int ACC_W = DATA_WIDTH + LOG2_SAMPLES;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] sum;

    // A clearing beat that is also a sample starts the sum from zero.
    assign base    = clear ? '0 : acc;
    assign sum     = base + ACC_W'(sample);
    // Truncating average; the upper bits are zero by construction.
    assign average = DATA_WIDTH'(sum >> LOG2_SAMPLES);

    always_ff @(posedge clock) begin
        if (reset) begin
            acc <= '0;
        end else if (add) begin
            acc <= sum;
        end else if (clear) begin
            acc <= '0;
        end
    end

endmodule

// File: rtl/blc_offset_est.sv
// Black-level offset estimator.
// Averages the first 2^LOG2_SAMPLES optical-black pixels of each frame per
// RGB channel and publishes the result as offset_out alongside each pixel
// beat. Pixel data and aux pass through a one-entry registered stage.
//
// Handshake (i/r ready): a beat moves in when u_i_ready && i_i_ready
// (insert) and leaves when i_r_ready && u_r_ready (remove). i_i_ready and
// i_r_ready are mutually exclusive, so insert and remove never coincide and
// the outputs are held stable while i_r_ready=1 and u_r_ready=0.
//
// Ports:
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   u_i_ready      : upstream beat valid
//   u_r_ready      : downstream ready for the current output beat
//   data_in/aux_in : pixel {R,G,B} and sideband (OB / SOF flags inside)
//   data_out/aux_out/offset_out : registered beat plus its black level
//   offset_valid   : at least one full average computed since reset
//   i_i_ready      : stage can accept a beat
//   i_r_ready      : output beat valid
module blc_offset_est
    import blc_offset_est_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int LOG2_SAMPLES   = 4,
    parameter int DEFAULT_OFFSET = 64,
    parameter int OB_BIT         = AUX_OB_BIT,
    parameter int SOF_BIT        = AUX_SOF_BIT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    u_i_ready,
    input  logic                    u_r_ready,
    input  logic [3*DATA_WIDTH-1:0] data_in,
    input  logic [3*DATA_WIDTH-1:0] aux_in,
    output logic [3*DATA_WIDTH-1:0] offset_out,
    output logic [3*DATA_WIDTH-1:0] data_out,
    output logic [3*DATA_WIDTH-1:0] aux_out,
    output logic                    offset_valid,
    output logic                    i_i_ready,
    output logic                    i_r_ready
);

    localparam int CNT_W = LOG2_SAMPLES + 1;
    localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(1 << LOG2_SAMPLES);
    localparam logic [DATA_WIDTH-1:0] DEF_CH = DATA_WIDTH'(DEFAULT_OFFSET);

    logic                    insert;
    logic                    remove;
    logic [1:0]              hs_event;
    logic                    sof;
    logic                    ob;
    logic                    sampling;
    logic                    complete;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        count_base;
    logic [CNT_W-1:0]        count_next;
    logic [1:0]              state;
    logic [3*DATA_WIDTH-1:0] offset_reg;
    logic [3*DATA_WIDTH-1:0] avg_next;

    assign insert   = u_i_ready && i_i_ready;
    assign remove   = i_r_ready && u_r_ready;
    assign hs_event = {insert, remove};

    assign sof = aux_in[SOF_BIT];
    assign ob  = aux_in[OB_BIT];

    // An SOF beat re-enters ACCUM and is itself treated as an ACCUM beat.
    assign sampling   = ob && (sof || (state == ST_ACCUM));
    assign count_base = sof ? '0 : count;
    assign count_next = count_base + CNT_W'(1);
    assign complete   = sampling && (count_next == COUNT_FULL);

    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        blc_ob_accum #(
            .DATA_WIDTH  (DATA_WIDTH),
            .LOG2_SAMPLES(LOG2_SAMPLES)
        ) u_accum (
            .clock  (clock),
            .reset  (reset),
            .clear  (insert && sof),
            .add    (insert && sampling),
            .sample (data_in[ch*DATA_WIDTH +: DATA_WIDTH]),
            .average(avg_next[ch*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // Registered pass-through stage.
    always_ff @(posedge clock) begin
        if (reset) begin
            i_i_ready  <= 1'b1;
            i_r_ready  <= 1'b0;
            data_out   <= '0;
            aux_out    <= '0;
            offset_out <= '0;
        end else begin
            case (hs_event)
                HS_INSERT: begin
                    data_out   <= data_in;
                    aux_out    <= aux_in;
                    // Offset as it stood before this beat's own update.
                    offset_out <= offset_reg;
                    i_i_ready  <= 1'b0;
                    i_r_ready  <= 1'b1;
                end
                HS_REMOVE: begin
                    i_i_ready <= 1'b1;
                    i_r_ready <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Estimator FSM: advances only on insert cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            count        <= '0;
            offset_reg   <= {3{DEF_CH}};
            offset_valid <= 1'b0;
        end else if (insert) begin
            if (complete) begin
                offset_reg   <= avg_next;
                offset_valid <= 1'b1;
                count        <= count_next;
                state        <= ST_DONE;
            end else if (sampling) begin
                count <= count_next;
                state <= ST_ACCUM;
            end else if (sof) begin
                count <= '0;
                state <= ST_ACCUM;
            end
        end
    end

endmodule

// File: tb/tb_blc_offset_est.sv
module tb_blc_offset_est;

    localparam int DW   = 12;
    localparam int L2   = 2;
    localparam int NS   = 1 << L2;
    localparam int W3   = 3 * DW;
    localparam logic [W3-1:0] DEF3 = {12'd64, 12'd64, 12'd64};
    localparam logic [W3-1:0] A_NONE = 36'd0;
    localparam logic [W3-1:0] A_OB   = 36'd1;
    localparam logic [W3-1:0] A_SOF  = 36'd2;
    localparam logic [W3-1:0] A_BOTH = 36'd3;

    logic          clock;
    logic          reset;
    logic          u_i_ready;
    logic          u_r_ready;
    logic [W3-1:0] data_in;
    logic [W3-1:0] aux_in;
    logic [W3-1:0] offset_out;
    logic [W3-1:0] data_out;
    logic [W3-1:0] aux_out;
    logic          offset_valid;
    logic          i_i_ready;
    logic          i_r_ready;

    blc_offset_est #(
        .DATA_WIDTH    (DW),
        .LOG2_SAMPLES  (L2),
        .DEFAULT_OFFSET(64),
        .OB_BIT        (0),
        .SOF_BIT       (1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .u_i_ready   (u_i_ready),
        .u_r_ready   (u_r_ready),
        .data_in     (data_in),
        .aux_in      (aux_in),
        .offset_out  (offset_out),
        .data_out    (data_out),
        .aux_out     (aux_out),
        .offset_valid(offset_valid),
        .i_i_ready   (i_i_ready),
        .i_r_ready   (i_r_ready)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  chk_en   = 1'b0;
    bit  rr_random = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W3-1:0] pix(input int r, input int g, input int b);
        logic [DW-1:0] rr, gg, bb;
        rr = DW'(r);
        gg = DW'(g);
        bb = DW'(b);
        return {rr, gg, bb};
    endfunction

    // ---------------- behavioural model ----------------
    // Expected queue entries: {aux, data, offset}.
    logic [3*W3-1:0] exp_q[$];
    logic [W3-1:0]   m_samples[$];
    logic [W3-1:0]   m_off;
    bit              m_valid;
    bit              m_collect;
    bit              m_in_rdy;
    bit              m_out_vld;

    always @(posedge clock) begin
        if (reset) begin
            m_in_rdy  = 1'b1;
            m_out_vld = 1'b0;
            exp_q.delete();
            m_samples.delete();
            m_off     = DEF3;
            m_valid   = 1'b0;
            m_collect = 1'b0;
        end else begin
            bit ins, rem;
            ins = u_i_ready && m_in_rdy;
            rem = m_out_vld && u_r_ready;
            if (rem) begin
                void'(exp_q.pop_front());
                m_out_vld = 1'b0;
                m_in_rdy  = 1'b1;
            end
            if (ins) begin
                exp_q.push_back({aux_in, data_in, m_off});
                m_in_rdy  = 1'b0;
                m_out_vld = 1'b1;
                if (aux_in[1]) begin
                    m_collect = 1'b1;
                    m_samples.delete();
                end
                if (m_collect && aux_in[0]) begin
                    m_samples.push_back(data_in);
                    if (m_samples.size() == NS) begin
                        for (int ch = 0; ch < 3; ch++) begin
                            int sum;
                            logic [W3-1:0] s;
                            sum = 0;
                            foreach (m_samples[k]) begin
                                s = m_samples[k];
                                sum += int'(s[ch*DW +: DW]);
                            end
                            m_off[ch*DW +: DW] = DW'(sum / NS);
                        end
                        m_valid   = 1'b1;
                        m_collect = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clock) begin
        if (chk_en && !reset) begin
            check("i_i_ready", 64'(i_i_ready), 64'(m_in_rdy));
            check("i_r_ready", 64'(i_r_ready), 64'(m_out_vld));
            check("offset_valid", 64'(offset_valid), 64'(m_valid));
            if (m_out_vld && exp_q.size() > 0) begin
                logic [3*W3-1:0] e;
                e = exp_q[0];
                check("aux_out", 64'(aux_out), 64'(e[3*W3-1:2*W3]));
                check("data_out", 64'(data_out), 64'(e[2*W3-1:W3]));
                check("offset_out", 64'(offset_out), 64'(e[W3-1:0]));
            end
        end
    end

    // ---------------- drivers ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_beat(input logic [W3-1:0] d, input logic [W3-1:0] a);
        int n;
        n = 0;
        u_i_ready = 1'b1;
        data_in   = d;
        aux_in    = a;
        while (!m_in_rdy && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 50) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: stage never ready at %0t", $time);
        end else begin
            @(posedge clock);
            #1;
        end
        u_i_ready = 1'b0;
    endtask

    task automatic pulse_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (rr_random) u_r_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset     = 1'b1;
        u_i_ready = 1'b0;
        u_r_ready = 1'b1;
        data_in   = '0;
        aux_in    = '0;
        repeat (3) @(posedge clock);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        // Reset state
        check("rst_i_i_ready", 64'(i_i_ready), 64'd1);
        check("rst_i_r_ready", 64'(i_r_ready), 64'd0);
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_aux_out", 64'(aux_out), 64'd0);
        check("rst_offset_out", 64'(offset_out), 64'd0);
        check("rst_offset_valid", 64'(offset_valid), 64'd0);

        // First beat carries the default offset
        send_beat(pix(5, 6, 7), A_NONE);
        check("first_offset", 64'(offset_out), 64'(DEF3));

        // Backpressure: hold 5 cycles, outputs stable
        @(posedge clock);
        #1;
        u_r_ready = 1'b0;
        send_beat(pix(1, 2, 3), 36'h800);
        repeat (5) begin
            @(negedge clock);
            check("bp_data", 64'(data_out), 64'(pix(1, 2, 3)));
            check("bp_aux", 64'(aux_out), 64'h800);
            check("bp_offset", 64'(offset_out), 64'(DEF3));
            check("bp_i_i_ready", 64'(i_i_ready), 64'd0);
        end
        @(posedge clock);
        #1;
        u_r_ready = 1'b1;
        @(posedge clock);
        #1;
        check("bp_removed", 64'(i_r_ready), 64'd0);

        // Full frame: R avg 258/4=64, G 10, B 4095
        send_beat(pix(1, 1, 1), A_SOF);
        send_beat(pix(60, 10, 4095), A_OB);
        send_beat(pix(64, 10, 4095), A_OB);
        send_beat(pix(68, 10, 4095), A_OB);
        check("valid_before_4th", 64'(offset_valid), 64'd0);
        send_beat(pix(66, 10, 4095), A_OB);
        check("valid_after_4th", 64'(offset_valid), 64'd1);
        send_beat(pix(0, 0, 0), A_NONE);
        check("frame1_offset", 64'(offset_out), 64'(pix(64, 10, 4095)));

        // Partial frame leaves offset unchanged
        send_beat(pix(9, 9, 9), A_SOF);
        send_beat(pix(200, 200, 200), A_OB);
        send_beat(pix(200, 200, 200), A_OB);
        send_beat(pix(9, 9, 9), A_SOF);
        send_beat(pix(0, 0, 0), A_NONE);
        check("partial_offset", 64'(offset_out), 64'(pix(64, 10, 4095)));
        check("partial_valid", 64'(offset_valid), 64'd1);

        // Frame continues (SOF already seen): 4 OB -> {100,200,300}
        repeat (4) send_beat(pix(100, 200, 300), A_OB);
        send_beat(pix(4000, 4000, 4000), A_OB);   // ignored in DONE
        send_beat(pix(0, 0, 0), A_NONE);
        check("done_offset", 64'(offset_out), 64'(pix(100, 200, 300)));

        // Reset in the middle of accumulation
        send_beat(pix(1000, 1000, 1000), A_BOTH);
        send_beat(pix(1000, 1000, 1000), A_OB);
        send_beat(pix(1000, 1000, 1000), A_OB);
        @(posedge clock);
        #1;
        pulse_reset(2);
        check("midrst_valid", 64'(offset_valid), 64'd0);
        send_beat(pix(1000, 1000, 1000), A_OB);   // no SOF yet: ignored
        check("midrst_offset", 64'(offset_out), 64'(DEF3));

        // Post-reset frame, SOF beat is also sample 1: {56/4, 6/4, 7}
        send_beat(pix(8, 0, 7), A_BOTH);
        send_beat(pix(12, 1, 7), A_OB);
        send_beat(pix(16, 2, 7), A_OB);
        send_beat(pix(20, 3, 7), A_OB);
        send_beat(pix(0, 0, 0), A_NONE);
        check("postrst_offset", 64'(offset_out), 64'(pix(14, 1, 7)));
        check("postrst_valid", 64'(offset_valid), 64'd1);

        // Random pass-through with toggling downstream ready
        rr_random = 1'b1;
        for (int i = 0; i < 60; i++) begin
            logic [W3-1:0] d, a;
            d = {4'($urandom_range(0, 15)), 32'($urandom)};
            a = {4'($urandom_range(0, 15)), 32'($urandom)};
            send_beat(d, a);
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #0;
        end
        rr_random = 1'b0;
        @(posedge clock);
        #1;
        u_r_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        check("drain_i_r_ready", 64'(i_r_ready), 64'd0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
